lcv_mul_acc_arbiter: RTL and testbench

//  Round-robin arbiter that shares one external 1-cycle multiply-accumulate unit
//  (outp <= a*b + c + d + e) between NUM_REQ requesters.

---
 rtl/lcv_mul_acc_arbiter.sv | 172 +++++++++++++++++
 tb/tb_lcv_mul_acc_arbiter.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/lcv_mul_acc_arbiter.sv
// Round-robin arbiter sharing one external 1-cycle multiply-accumulate unit
// (outp = a*b + c + d + e) between NUM_REQ requesters.
// Each requester may have at most one operation outstanding. An operation is
// either in the MAC pipeline or parked in that requester's response buffer.
// A result is steered back to its requester through a one-entry buffer.
module lcv_mul_acc_arbiter #(
  parameter int NUM_REQ = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  // request channel
  input  logic [NUM_REQ-1:0]    req_valid,
  output logic [NUM_REQ-1:0]    req_ready,
  input  logic [NUM_REQ*16-1:0] req_a,
  input  logic [NUM_REQ*16-1:0] req_b,
  input  logic [NUM_REQ*33-1:0] req_c,
  input  logic [NUM_REQ*33-1:0] req_d,
  input  logic [NUM_REQ*33-1:0] req_e,
  // response channel
  output logic [NUM_REQ-1:0]    rsp_valid,
  input  logic [NUM_REQ-1:0]    rsp_ready,
  output logic [NUM_REQ*33-1:0] rsp_data,
  // shared MAC interface
  output logic [15:0]           mac_a,
  output logic [15:0]           mac_b,
  output logic [32:0]           mac_c,
  output logic [32:0]           mac_d,
  output logic [32:0]           mac_e,
  input  logic [32:0]           mac_outp
);

  localparam int IDX_W = $clog2(NUM_REQ);
  localparam int OP_W  = 16;
  localparam int ADD_W = 33;

  // Registered state
  logic [IDX_W-1:0]   rr_ptr_q, rr_ptr_d;
  logic               inflight_valid_q, inflight_valid_d;
  logic [IDX_W-1:0]   inflight_idx_q, inflight_idx_d;
  logic [NUM_REQ-1:0] rsp_valid_q, rsp_valid_d;
  logic [ADD_W-1:0]   rsp_data_q [NUM_REQ];
  logic [ADD_W-1:0]   rsp_data_d [NUM_REQ];

  // Arbitration signals
  logic [NUM_REQ-1:0] fill_mask;
  logic [NUM_REQ-1:0] busy;
  logic [NUM_REQ-1:0] eligible;
  logic [IDX_W-1:0]   cand_idx;
  logic [IDX_W-1:0]   grant_idx;
  logic               grant_found;
  logic               accept;
  logic [NUM_REQ-1:0] grant_oh;

  // One-hot of the lane whose result arrives from the MAC this cycle.
  always_comb begin
    // NOTE: every variable written here gets a default before any condition,
    // so no path leaves it unassigned and no latch is inferred.
    fill_mask = '0;
    if (inflight_valid_q) begin
      fill_mask[inflight_idx_q] = 1'b1;
    end
  end

  // A lane is busy while its op is in the MAC or its result is unconsumed.
  assign busy     = fill_mask | rsp_valid_q;
  assign eligible = req_valid & ~busy;

  // Round-robin pick: first eligible lane after the last granted one.
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    cand_idx    = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      cand_idx = IDX_W'((int'(rr_ptr_q) + k) % NUM_REQ);
      if (!grant_found && eligible[cand_idx]) begin
        grant_found = 1'b1;
        grant_idx   = cand_idx;
      end
    end
  end

  // No grant is offered while reset is held, so nothing can be accepted then.
  assign accept    = grant_found && !rst;
  assign grant_oh  = accept ? (NUM_REQ'(1) << grant_idx) : '0;
  assign req_ready = grant_oh;

  // Present the granted lane's operands to the MAC; zeros when idle.
  always_comb begin
    mac_a = '0;
    mac_b = '0;
    mac_c = '0;
    mac_d = '0;
    mac_e = '0;
    if (accept) begin
      mac_a = req_a[grant_idx*OP_W  +: OP_W];
      mac_b = req_b[grant_idx*OP_W  +: OP_W];
      mac_c = req_c[grant_idx*ADD_W +: ADD_W];
      mac_d = req_d[grant_idx*ADD_W +: ADD_W];
      mac_e = req_e[grant_idx*ADD_W +: ADD_W];
    end
  end

  // Pointer and in-flight tag advance only on an accepted request.
  always_comb begin
    rr_ptr_d         = rr_ptr_q;
    inflight_idx_d   = inflight_idx_q;
    inflight_valid_d = accept;
    if (accept) begin
      rr_ptr_d       = grant_idx;
      inflight_idx_d = grant_idx;
    end
  end

  // Response buffers: consume clears, MAC result fills the tagged lane.
  // Fill and consume never hit the same lane because busy blocks its grant.
  always_comb begin
    rsp_valid_d = rsp_valid_q & ~rsp_ready;
    rsp_data_d  = rsp_data_q;
    if (inflight_valid_q) begin
      rsp_valid_d[inflight_idx_q] = 1'b1;
      rsp_data_d[inflight_idx_q]  = mac_outp;
    end
  end

  // State registers; reset discards in-flight and buffered results.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      // NOTE: sequential state uses non-blocking assignments so every flop
      // samples its pre-edge value regardless of statement order.
      rr_ptr_q         <= IDX_W'(NUM_REQ - 1);
      inflight_valid_q <= 1'b0;
      inflight_idx_q   <= '0;
      rsp_valid_q      <= '0;
      // NOTE: the result buffers are visible on rsp_data, whose reset value is
      // defined as zero, so this storage array is reset like any other flop.
      for (int i = 0; i < NUM_REQ; i++) begin
        rsp_data_q[i] <= '0;
      end
    end else begin
      rr_ptr_q         <= rr_ptr_d;
      inflight_valid_q <= inflight_valid_d;
      inflight_idx_q   <= inflight_idx_d;
      rsp_valid_q      <= rsp_valid_d;
      rsp_data_q       <= rsp_data_d;
    end
  end

  assign rsp_valid = rsp_valid_q;

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_rsp_data
    assign rsp_data[g*ADD_W +: ADD_W] = rsp_data_q[g];
  end

`ifndef SYNTHESIS
  // At most one lane is granted per cycle.
  a_ready_onehot0: assert property (@(posedge clk) disable iff (rst)
    $onehot0(req_ready));

  // A lane with an outstanding op is never granted.
  a_no_grant_busy: assert property (@(posedge clk) disable iff (rst)
    (req_ready & busy) == '0);

  // The MAC pipeline only holds an op that was accepted the cycle before.
  a_inflight_from_accept: assert property (@(posedge clk) disable iff (rst)
    inflight_valid_q |-> $past(accept));

  // A response buffer only becomes valid from a result of that lane.
  a_rsp_from_grant: assert property (@(posedge clk) disable iff (rst)
    (rsp_valid_q & ~$past(rsp_valid_q) & ~$past(fill_mask)) == '0);
`endif

endmodule

// File: tb/tb_lcv_mul_acc_arbiter.sv
// Directed bench for lcv_mul_acc_arbiter with a behavioural 1-cycle MAC.
// Inputs are driven just after the falling edge; outputs are sampled 1 ns later.
module tb_lcv_mul_acc_arbiter;

  localparam int N = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic            rst;
  logic [N-1:0]    req_valid, req_ready, rsp_valid, rsp_ready;
  logic [N*16-1:0] req_a, req_b;
  logic [N*33-1:0] req_c, req_d, req_e, rsp_data;
  logic [15:0]     mac_a, mac_b;
  logic [32:0]     mac_c, mac_d, mac_e, mac_outp;

  int n_checks = 0;
  int n_errors = 0;

  lcv_mul_acc_arbiter #(.NUM_REQ(N)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_a     (req_a),
    .req_b     (req_b),
    .req_c     (req_c),
    .req_d     (req_d),
    .req_e     (req_e),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_data  (rsp_data),
    .mac_a     (mac_a),
    .mac_b     (mac_b),
    .mac_c     (mac_c),
    .mac_d     (mac_d),
    .mac_e     (mac_e),
    .mac_outp  (mac_outp)
  );

  // External MAC: registered a*b + c + d + e, wrapping at 33 bits.
  function automatic logic [32:0] mac_model(input logic [15:0] a, input logic [15:0] b,
                                            input logic [32:0] c, input logic [32:0] d,
                                            input logic [32:0] e);
    logic signed [31:0] p;
    p = $signed(a) * $signed(b);
    return {p[31], p} + c + d + e;
  endfunction

  always @(posedge clk) mac_outp <= mac_model(mac_a, mac_b, mac_c, mac_d, mac_e);

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(negedge clk);
  endtask

  task automatic set_lane(input int i, input logic [15:0] a, input logic [15:0] b,
                          input logic [32:0] c, input logic [32:0] d, input logic [32:0] e);
    req_a[i*16 +: 16] = a;
    req_b[i*16 +: 16] = b;
    req_c[i*33 +: 33] = c;
    req_d[i*33 +: 33] = d;
    req_e[i*33 +: 33] = e;
  endtask

  function automatic logic [32:0] rsp_lane(input int i);
    return rsp_data[i*33 +: 33];
  endfunction

  // Lane i operands a=i+1, b=10, c=i -> results 10, 21, 32, 43.
  task automatic load_std_lanes();
    for (int i = 0; i < N; i++) set_lane(i, 16'(i + 1), 16'd10, 33'(i), 33'd0, 33'd0);
  endtask

  logic [63:0] lane_res [4]  = '{64'd10, 64'd21, 64'd32, 64'd43};
  // All lanes requesting, all responses consumed immediately.
  logic [3:0]  t2_gnt   [8]  = '{4'h1, 4'h2, 4'h4, 4'h8, 4'h1, 4'h2, 4'h4, 4'h8};
  logic [3:0]  t2_rsp   [8]  = '{4'h0, 4'h0, 4'h1, 4'h2, 4'h4, 4'h8, 4'h1, 4'h2};
  int          t2_rlane [8]  = '{0, 0, 0, 1, 2, 3, 0, 1};
  // Lane 1 holds its response until cycle 10.
  logic [3:0]  t3_gnt   [12] = '{4'h1, 4'h2, 4'h4, 4'h8, 4'h1, 4'h4,
                                 4'h8, 4'h1, 4'h4, 4'h8, 4'h1, 4'h2};
  logic        t3_rv1   [12] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1,
                                 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete within time limit");
    $fatal(1);
  end

  initial begin
    rst = 1'b1;
    req_valid = '1;
    rsp_ready = '0;
    req_a = '0; req_b = '0; req_c = '0; req_d = '0; req_e = '0;
    load_std_lanes();

    // Reset state, with every lane requesting
    cyc(); cyc(); #1;
    check("rst_req_ready", 64'(req_ready), 64'h0);
    check("rst_rsp_valid", 64'(rsp_valid), 64'h0);
    check("rst_mac_a", 64'(mac_a), 64'h0);
    for (int i = 0; i < N; i++) check($sformatf("rst_rsp_data%0d", i), 64'(rsp_lane(i)), 64'h0);

    cyc(); rst = 1'b0; req_valid = '0;

    // T1: single op on lane 0, 3*-4 + 10 + 1 + 2 = 1
    cyc();
    set_lane(0, 16'h0003, 16'hFFFC, 33'd10, 33'd1, 33'd2);
    req_valid = 4'b0001; #1;
    check("t1_grant", 64'(req_ready), 64'h1);
    check("t1_mac_a", 64'(mac_a), 64'h3);
    check("t1_mac_b", 64'(mac_b), 64'hFFFC);
    check("t1_mac_e", 64'(mac_e), 64'd2);
    cyc(); req_valid = '0; #1;
    check("t1_n1_rsp_valid", 64'(rsp_valid), 64'h0);
    check("t1_n1_mac_idle", 64'(mac_c), 64'h0);
    cyc(); #1;
    check("t1_n2_rsp_valid", 64'(rsp_valid), 64'h1);
    check("t1_n2_rsp_data", 64'(rsp_lane(0)), 64'h1);
    rsp_ready = 4'b0001;
    cyc(); rsp_ready = '0; #1;
    check("t1_consumed", 64'(rsp_valid), 64'h0);
    check("t1_data_hold", 64'(rsp_lane(0)), 64'h1);

    // T5: operand extremes on lane 0, back-to-back with response consumption
    cyc();
    set_lane(0, 16'h8000, 16'h8000, 33'd0, 33'd0, 33'd0);
    req_valid = 4'b0001; rsp_ready = 4'b0001; #1;
    check("t5a_grant", 64'(req_ready), 64'h1);
    cyc(); #1;
    check("t5a_inflight_no_grant", 64'(req_ready), 64'h0);
    cyc(); #1;
    check("t5a_rsp_valid", 64'(rsp_valid), 64'h1);
    check("t5a_rsp_data", 64'(rsp_lane(0)), 64'h0_4000_0000);
    check("t5a_buffered_no_grant", 64'(req_ready), 64'h0);
    cyc();
    set_lane(0, 16'h8000, 16'h8000, 33'h0_FFFF_FFFF, 33'h0_FFFF_FFFF, 33'h0_FFFF_FFFF); #1;
    check("t5b_regrant_after_consume", 64'(req_ready), 64'h1);
    check("t5b_mac_d", 64'(mac_d), 64'h0_FFFF_FFFF);
    cyc(); req_valid = '0; #1;
    cyc(); #1;
    check("t5b_rsp_valid", 64'(rsp_valid), 64'h1);
    check("t5b_rsp_data_wrap", 64'(rsp_lane(0)), 64'h1_3FFF_FFFD);
    cyc(); rsp_ready = '0; #1;
    check("t5b_consumed", 64'(rsp_valid), 64'h0);

    // T6: lane 3 pulses a request while its buffer is full
    cyc();
    set_lane(3, 16'h0002, 16'h0005, 33'd1, 33'd0, 33'd0);
    req_valid = 4'b1000; #1;
    check("t6_grant", 64'(req_ready), 64'h8);
    cyc(); req_valid = '0; #1;
    cyc();
    set_lane(3, 16'h1234, 16'h0007, 33'd5, 33'd6, 33'd7);
    req_valid = 4'b1000; #1;
    check("t6_rsp_valid", 64'(rsp_valid), 64'h8);
    check("t6_rsp_data", 64'(rsp_lane(3)), 64'd11);
    check("t6_busy_no_grant", 64'(req_ready), 64'h0);
    check("t6_busy_mac_a", 64'(mac_a), 64'h0);
    check("t6_busy_mac_b", 64'(mac_b), 64'h0);
    check("t6_busy_mac_c", 64'(mac_c), 64'h0);
    cyc(); req_valid = '0; #1;
    check("t6_p1_rsp_valid", 64'(rsp_valid), 64'h8);
    cyc(); #1;
    check("t6_p2_rsp_valid", 64'(rsp_valid), 64'h8);
    check("t6_p2_rsp_data", 64'(rsp_lane(3)), 64'd11);
    rsp_ready = 4'b1000;
    cyc(); rsp_ready = '0; #1;
    check("t6_consumed", 64'(rsp_valid), 64'h0);

    // T2: all lanes requesting from reset, responses consumed immediately
    cyc(); rst = 1'b1;
    cyc(); rst = 1'b0;
    load_std_lanes();
    req_valid = '1; rsp_ready = '1;
    for (int k = 0; k < 8; k++) begin
      if (k != 0) cyc();
      #1;
      check($sformatf("t2_grant_c%0d", k), 64'(req_ready), 64'(t2_gnt[k]));
      check($sformatf("t2_rsp_valid_c%0d", k), 64'(rsp_valid), 64'(t2_rsp[k]));
      if (t2_rsp[k] != 4'h0)
        check($sformatf("t2_rsp_data_c%0d", k), 64'(rsp_lane(t2_rlane[k])), lane_res[t2_rlane[k]]);
    end
    cyc(); req_valid = '0;
    cyc(); cyc(); cyc(); #1;
    check("t2_drained", 64'(rsp_valid), 64'h0);

    // T3: lane 1 stalls its response; others keep rotating
    cyc(); rst = 1'b1;
    cyc(); rst = 1'b0;
    req_valid = '1; rsp_ready = 4'b1101;
    for (int k = 0; k < 12; k++) begin
      if (k != 0) cyc();
      if (k == 10) rsp_ready = '1;
      #1;
      check($sformatf("t3_grant_c%0d", k), 64'(req_ready), 64'(t3_gnt[k]));
      check($sformatf("t3_rsp_valid1_c%0d", k), 64'(rsp_valid[1]), 64'(t3_rv1[k]));
    end
    check("t3_lane1_data", 64'(rsp_lane(1)), lane_res[1]);
    cyc(); req_valid = '0;
    cyc(); cyc(); cyc(); #1;
    check("t3_drained", 64'(rsp_valid), 64'h0);

    // T4: reset one cycle after accepting lane 2
    cyc(); req_valid = 4'b0100; #1;
    check("t4_grant_lane2", 64'(req_ready), 64'h4);
    cyc(); rst = 1'b1; req_valid = '1; #1;
    check("t4_rst_req_ready", 64'(req_ready), 64'h0);
    check("t4_rst_mac_a", 64'(mac_a), 64'h0);
    cyc(); #1;
    check("t4_rst_rsp_valid", 64'(rsp_valid), 64'h0);
    check("t4_rst_rsp_data2", 64'(rsp_lane(2)), 64'h0);
    cyc(); rst = 1'b0; #1;
    check("t4_first_grant_lane0", 64'(req_ready), 64'h1);
    cyc(); #1;
    check("t4_second_grant_lane1", 64'(req_ready), 64'h2);
    check("t4_no_stale_rsp", 64'(rsp_valid), 64'h0);
    cyc(); #1;
    check("t4_rsp_valid0", 64'(rsp_valid), 64'h1);
    check("t4_rsp_data0", 64'(rsp_lane(0)), lane_res[0]);
    check("t4_rsp_data2_clear", 64'(rsp_lane(2)), 64'h0);
    cyc(); req_valid = '0;
    cyc(); cyc();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
